mux_16_1_rr_scheduler: RTL and testbench
========================================

# mux_16_1_rr_scheduler

- Round-robin scheduler sharing one 16:1 MUX among 16 requesters.
- Per arbitration it picks one pending requester and drives the MUX `Select_In` and `Enable_In` for a bounded burst of beats.
- It then inserts a configurable gap and rotates priority.
- It sits directly in front of `MUX_16_1`: `Select_Out` and `MUX_Enable_Out` connect to the MUX select and enable pins.

## Interface
Parameters:
- BURST_LEN, 4: max beats per grant; legal 1..256.
- GAP_CYCLES, 1: idle cycles between grants; legal 0..15.

Ports:
- Clock_In  in  1  single clock; all state updates on rising edge.
- Reset_N_In  in  1  asynchronous, active-low reset.
- Enable_In  in  1  global scheduler enable.
- Request_In  in  16  bit i = requester i wants the MUX; level-held.
- Grant_Out  out  16  one-hot grant; all zero when no grant.
- Select_Out  out  4  index of granted requester, to MUX `Select_In`.
- MUX_Enable_Out  out  1  high exactly while a grant is active, to MUX `Enable_In`.
- Beat_Count_Out  out  8  beats completed in the current grant (0-based).
- Busy_Out  out  1  high in GRANT or GAP.
- Urgent_In  in  1  present only with MUX_SCHED_URGENT_EN.

## Operation
- **States:** IDLE, GRANT, GAP.
- **IDLE**
  - Arbitrates when Enable_In=1 and Request_In≠0.
  - Search starts at Last_Ptr+1 (mod 16) and picks the first set bit.
  - Next edge: Select_Out=pick, Grant_Out=1<<pick, MUX_Enable_Out=1, Beat_Count_Out=0, state=GRANT.
- **GRANT**
  - Each cycle is one beat; Beat_Count_Out increments every cycle.
  - Exit at the edge ending the beat where Beat_Count_Out==BURST_LEN-1.
  - Early exit: Request_In[Select_Out] sampled 0 ends the grant at that edge. The beat in progress still counts.
  - Exit actions:
    - Last_Ptr=Select_Out.
    - Grant_Out=0, MUX_Enable_Out=0, Beat_Count_Out=0.
    - State=GAP if GAP_CYCLES>0.
    - If GAP_CYCLES=0: arbitrate in the same cycle and go back-to-back to GRANT for the new pick, or to IDLE if nothing is pending.
- **GAP**
  - Counts GAP_CYCLES cycles with outputs deasserted, then IDLE.
  - Requests arriving during GAP wait for IDLE arbitration.
- **Enable_In=0**
  - In GRANT: the grant aborts at the next edge; Last_Ptr=Select_Out; state=IDLE.
  - In GAP: goes to IDLE at the next edge.
  - In IDLE: no arbitration.
- **Select_Out** holds its last value outside GRANT; the MUX is disabled, so the value is don't-care downstream.
- **Fairness:** with all 16 requesting, grants go 0,1,…,15,0 after reset. A requester waits at most 15 grants.
- **Beat counter:** 8 bits unsigned; compared against BURST_LEN-1; never wraps inside a grant.

## Timing
- **Reset (async assert, sync-safe release):**
  - State=IDLE, Last_Ptr=15, gap counter=0.
  - Grant_Out=0, Select_Out=0, MUX_Enable_Out=0, Beat_Count_Out=0, Busy_Out=0.
- **Request-to-grant latency:** 1 cycle from IDLE. Grant outputs are registered.
- **Grant length:** at most BURST_LEN cycles.
- **Turnaround:** grant drop to next grant = GAP_CYCLES+1 cycles. With GAP_CYCLES=0 it is 0 cycles (back-to-back).
- **Reset mid-grant:** all outputs clear immediately (asynchronously); no partial-state retention.
- **Simultaneous request drop and final beat:** single exit; Last_Ptr still advances.

## Configuration
- MUX_SCHED_URGENT_EN defined:
  - Urgent_In port exists.
  - At any arbitration point, Urgent_In=1 with Request_In[0]=1 grants requester 0 regardless of Last_Ptr.
  - An urgent grant does not update Last_Ptr.
  - Urgent never preempts an active grant.
- Not defined: Urgent_In is absent; pure round-robin.

## Structure
- **Package mux_sched_pkg:**
  - NUM_REQ=16, SEL_W=4, BEAT_W=8.
  - State enum typedef sched_state_t {IDLE, GRANT, GAP}.
- **Sub-module rr_pick_16:** combinational rotate-priority picker.
  - Inputs: req[15:0], last[3:0].
  - Outputs: valid, idx[3:0].
  - Reused by both the IDLE and the back-to-back arbitration paths.

## Test plan
- Reset, Request_In=16'h0000 for 10 cycles -> Grant_Out=0, MUX_Enable_Out=0, Busy_Out=0 throughout.
- Request_In=16'hFFFF held, BURST_LEN=4, GAP_CYCLES=1 -> grants 0,1,2,…,15,0. Each grant lasts 4 cycles with Beat_Count_Out 0→3, followed by a 1-cycle gap.
- Request_In=16'h0090, Last_Ptr=4 -> grant 7. Bit 7 then drops after 2 beats -> grant ends, then grant 4.
- GAP_CYCLES=0, Request_In=16'h0003 -> Select_Out 0 for 4 cycles, then 1 immediately; MUX_Enable_Out stays high.
- Enable_In driven low mid-grant of requester 5 -> next cycle IDLE with outputs 0. Re-enabling with all requests set -> grant 6.
- MUX_SCHED_URGENT_EN, Last_Ptr=3, Request_In=16'h0011, Urgent_In=1 -> grant 0. The next arbitration then grants 4.

Source files
------------

// File: rtl/mux_16_1_rr_scheduler_pkg.sv
// Shared constants, state type and helpers for the 16-requester round-robin MUX scheduler.
// Optional feature macro used by this slice: MUX_SCHED_URGENT_EN.
package mux_sched_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;
  localparam int BEAT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  function automatic logic [NUM_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux_16_1_rr_scheduler_if.sv
// Request/grant bundle between the requesters, the scheduler and the shared 16:1 MUX.
// Urgent_In exists only when MUX_SCHED_URGENT_EN is defined.
interface mux_16_1_rr_scheduler_if;
  import mux_sched_pkg::*;

  logic                 Enable_In;
  logic [NUM_REQ-1:0]   Request_In;
  logic [NUM_REQ-1:0]   Grant_Out;
  logic [SEL_W-1:0]     Select_Out;
  logic                 MUX_Enable_Out;
  logic [BEAT_W-1:0]    Beat_Count_Out;
  logic                 Busy_Out;
`ifdef MUX_SCHED_URGENT_EN
  logic                 Urgent_In;

  modport master (input Enable_In, Request_In, Urgent_In,
                  output Grant_Out, Select_Out, MUX_Enable_Out, Beat_Count_Out, Busy_Out);
  modport slave  (output Enable_In, Request_In, Urgent_In,
                  input Grant_Out, Select_Out, MUX_Enable_Out, Beat_Count_Out, Busy_Out);
`else
  modport master (input Enable_In, Request_In,
                  output Grant_Out, Select_Out, MUX_Enable_Out, Beat_Count_Out, Busy_Out);
  modport slave  (output Enable_In, Request_In,
                  input Grant_Out, Select_Out, MUX_Enable_Out, Beat_Count_Out, Busy_Out);
`endif
endinterface

// File: rtl/mux_16_1_rr_scheduler_pick.sv
// Combinational rotate-priority picker: first set request bit searching upward from last+1.
module rr_pick_16
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // rot[0] is the highest-priority candidate (last+1), wrapping modulo 16.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[last + SEL_W'(gi + 1)];
  end

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign valid = |req;
  assign idx   = last + SEL_W'(1) + off;

endmodule

// File: rtl/mux_16_1_rr_scheduler.sv
// Round-robin scheduler driving the select/enable pins of a shared 16:1 MUX in bounded bursts.
// Define MUX_SCHED_URGENT_EN to add the Urgent_In override for requester 0.
module mux_16_1_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 1
)(
  input  logic                     Clock_In,
  input  logic                     Reset_N_In,
  mux_16_1_rr_scheduler_if.master  bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [3:0]        GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t        state_reg;
  logic [SEL_W-1:0]    last_ptr_reg;
  logic [SEL_W-1:0]    select_reg;
  logic [NUM_REQ-1:0]  grant_reg;
  logic                mux_en_reg;
  logic                busy_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic [3:0]          gap_reg;
  logic                urgent_grant_reg;

  logic                urgent_hit;
  logic [SEL_W-1:0]    exit_last;
  logic [SEL_W-1:0]    pick_last;
  logic                pick_valid;
  logic [SEL_W-1:0]    pick_idx;
  logic [SEL_W-1:0]    arb_idx;
  logic                grant_done;

`ifdef MUX_SCHED_URGENT_EN
  assign urgent_hit = bus.Urgent_In & bus.Request_In[0];
`else
  assign urgent_hit = 1'b0;
`endif

  // An urgent grant leaves the rotation pointer where it was.
  assign exit_last  = urgent_grant_reg ? last_ptr_reg : select_reg;
  // One picker serves both IDLE and back-to-back arbitration; the latter sees the post-exit pointer.
  assign pick_last  = (state_reg == GRANT) ? exit_last : last_ptr_reg;
  assign arb_idx    = urgent_hit ? '0 : pick_idx;
  assign grant_done = (beat_reg == LAST_BEAT) || !bus.Request_In[select_reg];

  rr_pick_16 u_pick (
    .req   (bus.Request_In),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_reg        <= IDLE;
      last_ptr_reg     <= SEL_W'(NUM_REQ - 1);
      select_reg       <= '0;
      grant_reg        <= '0;
      mux_en_reg       <= 1'b0;
      busy_reg         <= 1'b0;
      beat_reg         <= '0;
      gap_reg          <= '0;
      urgent_grant_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Enable_In && pick_valid) begin
            state_reg        <= GRANT;
            select_reg       <= arb_idx;
            grant_reg        <= onehot_sel(arb_idx);
            mux_en_reg       <= 1'b1;
            busy_reg         <= 1'b1;
            beat_reg         <= '0;
            urgent_grant_reg <= urgent_hit;
          end
        end
        GRANT: begin
          if (!bus.Enable_In) begin
            state_reg        <= IDLE;
            last_ptr_reg     <= exit_last;
            grant_reg        <= '0;
            mux_en_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            beat_reg         <= '0;
            urgent_grant_reg <= 1'b0;
          end else if (grant_done) begin
            last_ptr_reg <= exit_last;
            beat_reg     <= '0;
            if (GAP_CYCLES > 0) begin
              state_reg        <= GAP;
              gap_reg          <= GAP_LOAD;
              grant_reg        <= '0;
              mux_en_reg       <= 1'b0;
              busy_reg         <= 1'b1;
              urgent_grant_reg <= 1'b0;
            end else if (pick_valid) begin
              state_reg        <= GRANT;
              select_reg       <= arb_idx;
              grant_reg        <= onehot_sel(arb_idx);
              mux_en_reg       <= 1'b1;
              busy_reg         <= 1'b1;
              urgent_grant_reg <= urgent_hit;
            end else begin
              state_reg        <= IDLE;
              grant_reg        <= '0;
              mux_en_reg       <= 1'b0;
              busy_reg         <= 1'b0;
              urgent_grant_reg <= 1'b0;
            end
          end else begin
            beat_reg <= beat_reg + BEAT_W'(1);
          end
        end
        GAP: begin
          if (!bus.Enable_In || gap_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            gap_reg   <= '0;
          end else begin
            gap_reg <= gap_reg - 4'd1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          grant_reg  <= '0;
          mux_en_reg <= 1'b0;
          busy_reg   <= 1'b0;
          beat_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.Grant_Out      = grant_reg;
  assign bus.Select_Out     = select_reg;
  assign bus.MUX_Enable_Out = mux_en_reg;
  assign bus.Beat_Count_Out = beat_reg;
  assign bus.Busy_Out       = busy_reg;

endmodule

// File: tb/tb_mux_16_1_rr_scheduler.sv
// Randomized bench for the round-robin MUX scheduler: two configurations against a behavioural model.
module tb_mux_16_1_rr_scheduler;
  import mux_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_16_1_rr_scheduler_if ifa ();
  mux_16_1_rr_scheduler_if ifb ();

  mux_16_1_rr_scheduler #(.BURST_LEN(4), .GAP_CYCLES(1)) dut_a (
    .Clock_In(clk), .Reset_N_In(rst_n), .bus(ifa));
  mux_16_1_rr_scheduler #(.BURST_LEN(3), .GAP_CYCLES(0)) dut_b (
    .Clock_In(clk), .Reset_N_In(rst_n), .bus(ifb));

  // owner = granted requester or -1; gap_left = gap cycles still to spend including the current one.
  typedef struct {
    int owner;
    int sel;
    int beats;
    int gap_left;
    bit in_gap;
    int last;
  } mdl_t;

  mdl_t ma, mb;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   fair_on = 0;
  int   fair_exp = 0;
  logic prev_me_a = 1'b0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = -1; m.sel = 0; m.beats = 0; m.gap_left = 0; m.in_gap = 0; m.last = 15;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit en, logic [15:0] req, int burst, int gapc);
    mdl_t n = m;
    bit   want_arb = 0;
    bit   found = 0;
    int   cand;
    if (m.owner >= 0) begin
      if (!en) begin
        n.last = m.owner; n.owner = -1; n.beats = 0;
      end else if (m.beats == burst - 1 || !req[m.owner]) begin
        n.last = m.owner; n.owner = -1; n.beats = 0;
        if (gapc > 0) begin
          n.in_gap = 1; n.gap_left = gapc;
        end else begin
          want_arb = 1;
        end
      end else begin
        n.beats = m.beats + 1;
      end
    end else if (m.in_gap) begin
      if (!en || m.gap_left == 1) n.in_gap = 0;
      else n.gap_left = m.gap_left - 1;
    end else begin
      want_arb = en;
    end
    if (want_arb) begin
      for (int k = 1; k <= 16; k++) begin
        cand = (n.last + k) % 16;
        if (!found && req[cand]) begin
          found = 1; n.owner = cand; n.sel = cand; n.beats = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input string who, input mdl_t m, input logic [15:0] g,
                           input logic [3:0] s, input logic me, input logic [7:0] b,
                           input logic bz);
    logic [31:0] exp_g;
    exp_g = (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
    check_eq({who, ".grant"},  32'(g),  exp_g);
    check_eq({who, ".select"}, 32'(s),  32'(m.sel));
    check_eq({who, ".mux_en"}, 32'(me), 32'(m.owner >= 0));
    check_eq({who, ".beat"},   32'(b),  32'(m.beats));
    check_eq({who, ".busy"},   32'(bz), 32'((m.owner >= 0) || m.in_gap));
  endtask

  task automatic check_both();
    check_dut("A", ma, ifa.Grant_Out, ifa.Select_Out, ifa.MUX_Enable_Out,
              ifa.Beat_Count_Out, ifa.Busy_Out);
    check_dut("B", mb, ifb.Grant_Out, ifb.Select_Out, ifb.MUX_Enable_Out,
              ifb.Beat_Count_Out, ifb.Busy_Out);
  endtask

  task automatic drive(input bit en, input logic [15:0] req);
    ifa.Enable_In = en;  ifa.Request_In = req;
    ifb.Enable_In = en;  ifb.Request_In = req;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    ma = mdl_step(ma, ifa.Enable_In, ifa.Request_In, 4, 1);
    mb = mdl_step(mb, ifb.Enable_In, ifb.Request_In, 3, 0);
    #1;
    check_both();
    if (ma.owner >= 0 && ma.beats == 0)
      $display("cycle %0d: A grants requester %0d (req=0x%04h)", cyc, ma.owner, ifa.Request_In);
    if (mb.owner >= 0 && mb.beats == 0)
      $display("cycle %0d: B grants requester %0d (req=0x%04h)", cyc, mb.owner, ifb.Request_In);
    // With every requester asserting, grant order must walk 0,1,...,15,0.
    if (fair_on && ifa.MUX_Enable_Out && !prev_me_a) begin
      check_eq("A.fair_order", 32'(ifa.Select_Out), 32'(fair_exp));
      fair_exp = (fair_exp + 1) % 16;
    end
    prev_me_a = ifa.MUX_Enable_Out;
  endtask

  initial begin
    logic [15:0] req;
    bit          en;
`ifdef MUX_SCHED_URGENT_EN
    ifa.Urgent_In = 1'b0;
    ifb.Urgent_In = 1'b0;
`endif
    ma = mdl_reset();
    mb = mdl_reset();
    drive(1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check_both();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Enabled but nothing requested: everything must stay idle.
    drive(1'b1, 16'h0000);
    repeat (10) cycle();

    drive(1'b1, 16'hFFFF);
    fair_on = 1;
    repeat (110) cycle();
    fair_on = 0;

    req = 16'h0090;
    en  = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: req = 16'hFFFF;
          1: req = 16'($urandom);
          2: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
          default: req = 16'h0001 << $urandom_range(15);
        endcase
      end
      en = ($urandom_range(15) != 0);
      drive(en, req);
      if (i == 700) begin
        // Asynchronous reset between edges must clear outputs at once.
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check_both();
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
